// File: rtl/fpu_arbiter_if.sv
// rtl/fpu_arbiter_if.sv - request/response handshake bundle between two requesters and the fpu arbiter
interface fpu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  req1_op;
    logic        resp0_valid;
    logic        resp0_ready;
    logic [31:0] resp0_data;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp1_data;

    // requester side: issues operations, consumes results
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_data, resp1_valid, resp1_data,
        output resp0_ready, resp1_ready
    );

    // arbiter side: accepts operations, returns results
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_data, resp1_valid, resp1_data,
        input  resp0_ready, resp1_ready
    );
endinterface

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-requester round-robin front end for the single-precision fpu
module fpu_arbiter #(
    parameter int FPU_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fpu_arbiter_if.slave       bus,
    output logic [31:0]        fpu_a,
    output logic [31:0]        fpu_b,
    output logic [1:0]         fpu_opcode,
    input  logic [31:0]        fpu_o,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(FPU_LAT);

    state_t             state;
    logic               last_grant;
    logic               owner;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        result;
    logic               grant_valid;
    logic               grant_id;
    logic               handshake;

    // pick the requester for this IDLE cycle; on a tie the one not served last wins
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // the granted valid is always high when grant_valid is, so this is valid && ready
    assign handshake      = (state == IDLE) && grant_valid;
    assign bus.req0_ready = (state == IDLE) && grant_valid && !grant_id;
    assign bus.req1_ready = (state == IDLE) && grant_valid &&  grant_id;

    // only the owning port sees the result; the other port reads zero
    assign bus.resp0_valid = (state == RESP) && !owner;
    assign bus.resp1_valid = (state == RESP) &&  owner;
    assign bus.resp0_data  = bus.resp0_valid ? result : 32'h0;
    assign bus.resp1_data  = bus.resp1_valid ? result : 32'h0;
    assign busy            = (state != IDLE);

    // single-operation FSM: latch operands, wait out fpu latency, present result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            result     <= 32'h0;
            fpu_a      <= 32'h0;
            fpu_b      <= 32'h0;
            fpu_opcode <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        fpu_a      <= grant_id ? bus.req1_a  : bus.req0_a;
                        fpu_b      <= grant_id ? bus.req1_b  : bus.req0_b;
                        fpu_opcode <= grant_id ? bus.req1_op : bus.req0_op;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == LAT_CNT) begin
                        result <= fpu_o;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (owner ? bus.resp1_ready : bus.resp0_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed vector bench for fpu_arbiter with fpu stubs at latency 1 and 3
module tb_fpu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] fpu_a1, fpu_b1, fpu_o1;
    logic [1:0]  fpu_op1;
    logic        busy1;
    logic [31:0] fpu_a3, fpu_b3, fpu_o3;
    logic [1:0]  fpu_op3;
    logic        busy3;
    logic [31:0] p3_0, p3_1, p3_2;

    int tests_run;
    int tests_failed;

    fpu_arbiter_if bus();
    fpu_arbiter_if bus3();

    fpu_arbiter #(.FPU_LAT(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .fpu_a(fpu_a1), .fpu_b(fpu_b1), .fpu_opcode(fpu_op1),
        .fpu_o(fpu_o1), .busy(busy1)
    );

    fpu_arbiter #(.FPU_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .fpu_a(fpu_a3), .fpu_b(fpu_b3), .fpu_opcode(fpu_op3),
        .fpu_o(fpu_o3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fpu stand-in: exact IEEE results for the operand sets used here, a^b otherwise
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        if (a == 32'h3FC00000 && b == 32'h40100000 && op == 2'b00) return 32'h40700000;
        if (a == 32'h40000000 && b == 32'h40400000 && op == 2'b11) return 32'h40C00000;
        if (a == 32'h40A00000 && b == 32'h3F800000 && op == 2'b01) return 32'h40800000;
        if (a == 32'h3F800000 && b == 32'h3F800000 && op == 2'b00) return 32'h40000000;
        return a ^ b;
    endfunction

    always @(posedge clk) fpu_o1 <= fpu_model(fpu_a1, fpu_b1, fpu_op1);

    always @(posedge clk) begin
        p3_0 <= fpu_model(fpu_a3, fpu_b3, fpu_op3);
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign fpu_o3 = p3_2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic resp_v(input int p);
        return (p != 0) ? bus.resp1_valid : bus.resp0_valid;
    endfunction

    function automatic logic [31:0] resp_d(input int p);
        return (p != 0) ? bus.resp1_data : bus.resp0_data;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] op);
        if (p != 0) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic set_resp_ready(input int p, input logic r);
        if (p != 0) bus.resp1_ready = r;
        else        bus.resp0_ready = r;
    endtask

    // single transaction on port p; operands are scribbled after the handshake
    task automatic run_txn(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] exp, input int stall);
        int n;
        @(negedge clk);
        set_req(p, 1'b1, a, b, op);
        #1;
        check("req_ready", (p != 0) ? bus.req1_ready : bus.req0_ready, 1);
        check("other_req_ready", (p != 0) ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        set_req(p, 1'b0, ~a, 32'hDEADBEEF, ~op);
        n = 1;
        while (!resp_v(p) && n < 20) begin
            check("fpu_a_stable", fpu_a1, a);
            check("fpu_b_stable", fpu_b1, b);
            check("fpu_op_pass", {30'h0, fpu_op1}, {30'h0, op});
            @(negedge clk);
            n++;
        end
        check("latency", n, 3);
        set_req(1 - p, 1'b1, 32'h1, 32'h2, 2'b00);
        for (int s = 0; s < stall; s++) begin
            #1;
            check("stall_valid", resp_v(p), 1);
            check("stall_data", resp_d(p), exp);
            check("stall_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
            @(negedge clk);
        end
        set_req(1 - p, 1'b0, 32'h0, 32'h0, 2'b00);
        check("resp_valid", resp_v(p), 1);
        check("resp_data", resp_d(p), exp);
        check("other_resp_valid", resp_v(1 - p), 0);
        check("other_resp_data", resp_d(1 - p), 0);
        set_resp_ready(p, 1'b1);
        @(negedge clk);
        set_resp_ready(p, 1'b0);
        check("idle_after_resp", busy1, 0);
        check("resp_dropped", resp_v(p), 0);
        check("fpu_a_retained", fpu_a1, a);
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          n;
        int          g;
        logic        seen;
        logic [31:0] rr_exp [2];

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        bus3.req0_valid = 1'b0; bus3.req0_a = 32'h0; bus3.req0_b = 32'h0; bus3.req0_op = 2'b00;
        bus3.req1_valid = 1'b0; bus3.req1_a = 32'h0; bus3.req1_b = 32'h0; bus3.req1_op = 2'b00;
        bus3.resp0_ready = 1'b0;
        bus3.resp1_ready = 1'b0;

        vecs[0] = '{0, 32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 0};
        vecs[1] = '{1, 32'h40000000, 32'h40400000, 2'b11, 32'h40C00000, 5};
        vecs[2] = '{0, 32'h40A00000, 32'h3F800000, 2'b01, 32'h40800000, 2};
        vecs[3] = '{1, 32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 0};
        vecs[4] = '{1, 32'h12345678, 32'h0F0F0F0F, 2'b10, 32'h1D3B5977, 1};

        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_fpu_a", fpu_a1, 0);
        check("rst_fpu_b", fpu_b1, 0);
        check("rst_fpu_op", {30'h0, fpu_op1}, 0);
        check("rst_valids", {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid}, 0);
        check("rst_resp_data", bus.resp0_data | bus.resp1_data, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].stall);
        end

        // round-robin tie: both requesters hold valid continuously
        rr_exp[0] = 32'h40800000;
        rr_exp[1] = 32'h40000000;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 32'h40A00000, 32'h3F800000, 2'b01);
        set_req(1, 1'b1, 32'h3F800000, 32'h3F800000, 2'b00);
        for (int i = 0; i < 4; i++) begin
            #1;
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("rr_ready_seen", (n < 20) ? 1 : 0, 1);
            g = bus.req1_ready ? 1 : 0;
            check("rr_grant", g, i % 2);
            check("rr_one_ready", bus.req0_ready & bus.req1_ready, 0);
            @(posedge clk);
            @(negedge clk);
            n = 1;
            while (!(bus.resp0_valid || bus.resp1_valid) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rr_latency", n, 3);
            check("rr_resp_port", bus.resp1_valid ? 1 : 0, g);
            check("rr_resp_data", resp_d(g), rr_exp[g]);
            check("rr_other_resp", resp_v(1 - g), 0);
            check("rr_no_ready_in_resp", {bus.req0_ready, bus.req1_ready}, 0);
            @(negedge clk);
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_req(1, 1'b0, 32'h0, 32'h0, 2'b00);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        @(negedge clk);
        check("rr_idle", busy1, 0);

        // async reset in the middle of WAIT
        set_req(0, 1'b1, 32'h3FC00000, 32'h40100000, 2'b00);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        check("mid_busy_before_rst", busy1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy1, 0);
        check("arst_fpu_a", fpu_a1, 0);
        check("arst_fpu_b", fpu_b1, 0);
        check("arst_fpu_op", {30'h0, fpu_op1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp0_valid || bus.resp1_valid) seen = 1'b1;
        end
        check("arst_no_resp", seen, 0);
        set_req(0, 1'b1, 32'h3F800000, 32'h3F800000, 2'b00);
        set_req(1, 1'b1, 32'h40000000, 32'h40400000, 2'b11);
        #1;
        check("arst_tie_req0", bus.req0_ready, 1);
        check("arst_tie_req1", bus.req1_ready, 0);
        bus.req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
        n = 1;
        while (!bus.resp0_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arst_next_latency", n, 3);
        check("arst_next_data", bus.resp0_data, 32'h40000000);
        @(negedge clk);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;

        // latency-3 build: resp first high FPU_LAT+2 = 5 cycles after handshake
        @(negedge clk);
        bus3.req0_valid = 1'b1;
        bus3.req0_a     = 32'h3FC00000;
        bus3.req0_b     = 32'h40100000;
        bus3.req0_op    = 2'b00;
        #1;
        check("lat3_ready", bus3.req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus3.req0_valid = 1'b0;
        bus3.req0_a     = 32'h0;
        n = 1;
        while (!bus3.resp0_valid && n < 30) begin
            check("lat3_busy", busy3, 1);
            @(negedge clk);
            n++;
        end
        check("lat3_latency", n, 5);
        check("lat3_data", bus3.resp0_data, 32'h40700000);
        check("lat3_other_resp", bus3.resp1_valid, 0);
        bus3.resp0_ready = 1'b1;
        @(negedge clk);
        bus3.resp0_ready = 1'b0;
        check("lat3_idle", busy3, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Two-requester front end for the single-precision `fpu` block.
- Accepts operand/opcode transactions on valid/ready request ports and arbitrates between them round-robin.
- Drives the `fpu` A/B/opcode inputs and holds them stable for the `fpu` register latency.
- Captures the `fpu` output and returns it to the issuing requester on a valid/ready response port. Only one operation is in flight at a time.

Parameters:
- FPU_LAT, 1: number of clk edges the `fpu` needs to register O after its inputs are stable. Must be >= 1.
- CNT_W, 4: width of the wait counter. Must hold FPU_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand A (IEEE 754 single).
- req0_b  in  32  requester 0 operand B.
- req0_op  in  2  requester 0 opcode: 00 add, 01 sub, 10 div, 11 mul.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 accepts result.
- resp0_data  out  32  result for requester 0.
- resp1_valid, resp1_ready, resp1_data: same as requester 0, for requester 1.
- fpu_a  out  32  to `fpu` A.
- fpu_b  out  32  to `fpu` B.
- fpu_opcode  out  2  to `fpu` opcode.
- fpu_o  in  32  from `fpu` O.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - fpu_a, fpu_b, fpu_opcode, result register, owner and counter = 0.
  - All valid/ready outputs are 0.
  - Reset mid-operation aborts the operation; no response is ever issued for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE, grant selection (combinational):
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester != last_grant.
- IDLE, ready: reqN_ready = (state==IDLE) && granted==N. Ready may depend combinationally on valid. Never both readies high.
- IDLE, handshake (valid && ready on the granted port):
  - At the edge: register operands into fpu_a/fpu_b/fpu_opcode; owner = N; last_grant = N; cnt = 0; state -> WAIT.
- WAIT:
  - fpu_* outputs are held constant. cnt increments each cycle.
  - When cnt == FPU_LAT: result <= fpu_o, state -> RESP.
  - WAIT therefore lasts FPU_LAT+1 cycles.
- RESP:
  - resp{owner}_valid = 1 and resp{owner}_data = result. The other response port stays 0 with data 0.
  - Hold until resp{owner}_ready is high. At that edge, state -> IDLE.
  - The result register and fpu_* values are retained, not cleared.
- Latency: request handshake in cycle c0 -> resp_valid first high in cycle c0+FPU_LAT+2. With FPU_LAT=1 this is 3 cycles.
- Throughput: at most one operation per FPU_LAT+3 cycles, assuming zero response stall.
- No request is accepted in WAIT or RESP; both req_ready stay 0, including while a response is stalled.
- A requester may drop valid before its handshake; no transaction occurs and arbitration re-evaluates each IDLE cycle.
- The arbiter does not inspect operands or the result; NaN/inf/zero handling is the `fpu`'s responsibility. Opcode is passed through verbatim.
- Simultaneous response acceptance and a new request in the same cycle: the request is not accepted until the following cycle, when state is IDLE.

Test Plan:
- Basic add: after reset, req0 a=0x3FC00000, b=0x40100000, op=00 -> req0_ready in c0; resp0_valid in c3 with resp0_data=0x40700000; resp1_valid stays 0.
- Mul on req1 with response stall: a=0x40000000, b=0x40400000, op=11; hold resp1_ready=0 for 5 cycles -> resp1_valid held high with data=0x40C00000 throughout; req0_ready=0 and req1_ready=0 during the stall; IDLE after resp1_ready pulses.
- Round-robin tie: both valid continuously, req0 sub 0x40A00000-0x3F800000, req1 add 0x3F800000+0x3F800000 -> grant order 0,1,0,1; results 0x40800000 to port 0 and 0x40000000 to port 1, each on its own port only.
- Operand stability: change req0_a/req0_b during WAIT -> fpu_a/fpu_b unchanged until the next handshake; result unaffected.
- Async reset mid-WAIT: assert rst_n low between clk edges during WAIT -> outputs zero immediately; no resp_valid after release; next request is granted to req0 on a tie.
- FPU_LAT=3 build: single add as in the first scenario -> resp0_valid first high in c0+5 with correct data.
